// File: rtl/n2r_slice_sched_if.sv
// n2r_slice_sched_if
//   Handshake bundle between the slice scheduler, the row source, the n2r
//   buffer and the matmul core array.
//   master : the scheduler (drives in_ready, buf_advance, mm_start, mm_valid)
//   slave  : the surrounding datapath (drives in_valid, buf_out_valid,
//            buf_slice_done, mm_ready, mm_done)
interface n2r_slice_sched_if;
  logic in_valid;
  logic in_ready;
  logic buf_advance;
  logic buf_out_valid;
  logic buf_slice_done;
  logic mm_ready;
  logic mm_start;
  logic mm_valid;
  logic mm_done;

  modport master (
    input  in_valid,
    output in_ready,
    output buf_advance,
    input  buf_out_valid,
    input  buf_slice_done,
    input  mm_ready,
    output mm_start,
    output mm_valid,
    input  mm_done
  );

  modport slave (
    output in_valid,
    input  in_ready,
    input  buf_advance,
    output buf_out_valid,
    output buf_slice_done,
    output mm_ready,
    input  mm_start,
    input  mm_valid,
    output mm_done
  );
endinterface

// File: rtl/n2r_slice_sched.sv
// n2r_slice_sched
//   Sequencing controller for one matrix pass: loads ROW rows from upstream
//   into the n2r buffer, then releases them to the matmul cores one slice
//   (BLOCK_SIZE*NUM_CORES rows) at a time, freezing the buffer while the
//   cores are not ready. Owns start/stall/done/error signalling.
// Ports
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   start      : begin a pass (sampled only when idle)
//   bus        : n2r_slice_sched_if.master (row, buffer and core handshakes)
//   slice_idx  : slice currently being streamed
//   busy       : pass in progress
//   done       : one-cycle pulse at end of pass
//   err        : sticky protocol error, cleared by an accepted start
// Build option
//   N2R_SLICE_SCHED_WDOG_EN : inactivity watchdog of WDOG_CYCLES cycles in
//   WAIT_MM/STREAM/DRAIN; on expiry sets err and returns to IDLE without done.
module n2r_slice_sched #(
  parameter  int unsigned ROW         = 2754,
  parameter  int unsigned COL         = 256,
  parameter  int unsigned BLOCK_SIZE  = 2,
  parameter  int unsigned NUM_CORES   = 8,
  parameter  int unsigned WDOG_CYCLES = 1024,
  localparam int unsigned SLICE_ROWS  = BLOCK_SIZE * NUM_CORES,
  localparam int unsigned NUM_SLICES  = (ROW + SLICE_ROWS - 1) / SLICE_ROWS,
  localparam int unsigned CHUNKS      = COL / BLOCK_SIZE,
  localparam int unsigned SIDX_W      = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  n2r_slice_sched_if.master     bus,
  output logic [SIDX_W-1:0]     slice_idx,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int unsigned RW = (ROW > 1) ? $clog2(ROW) : 1;
  localparam int unsigned CW = $clog2(CHUNKS) + 1;

  localparam logic [RW-1:0]     ROW_LAST   = RW'(ROW - 1);
  localparam logic [CW-1:0]     CHUNK_LAST = CW'(CHUNKS - 1);
  localparam logic [SIDX_W-1:0] SLICE_LAST = SIDX_W'(NUM_SLICES - 1);

  if (ROW == 0 || BLOCK_SIZE == 0 || NUM_CORES == 0 || CHUNKS == 0 ||
      WDOG_CYCLES == 0) begin : g_bad_cfg
    $error("n2r_slice_sched: invalid parameter set");
  end

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT_MM,
    STREAM,
    DRAIN,
    DONE
  } state_t;

  state_t          state;
  logic [RW-1:0]   row_cnt;
  logic [CW-1:0]   chunk_cnt;
  logic            outstanding;  // slice handed to cores, mm_done not yet seen
  logic            wait_done;    // slice streamed, holding in STREAM for mm_done
  logic            mm_start_q;
  logic            mm_valid_q;

`ifdef N2R_SLICE_SCHED_WDOG_EN
  localparam int unsigned WW = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
  localparam logic [WW-1:0] WDOG_LAST = WW'(WDOG_CYCLES - 1);
  logic [WW-1:0] wdog_cnt;
`endif

  assign bus.in_ready    = (state == LOAD);
  assign bus.buf_advance = (state == LOAD) || (state == STREAM && !wait_done);
  assign bus.mm_start    = mm_start_q;
  assign bus.mm_valid    = mm_valid_q;
  assign busy            = (state != IDLE);
  assign done            = (state == DONE);

  // A latched mm_done is simply outstanding==0: mm_done clears it, mm_start
  // sets it, and an mm_done while it is already clear is a protocol error.
  // mm_valid is the registered copy of buf_out_valid so no input reaches an
  // output combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      row_cnt     <= '0;
      chunk_cnt   <= '0;
      slice_idx   <= '0;
      err         <= 1'b0;
      outstanding <= 1'b0;
      wait_done   <= 1'b0;
      mm_start_q  <= 1'b0;
      mm_valid_q  <= 1'b0;
`ifdef N2R_SLICE_SCHED_WDOG_EN
      wdog_cnt    <= '0;
`endif
    end else begin
      mm_start_q <= 1'b0;
      mm_valid_q <= 1'b0;

      if (bus.mm_done) begin
        outstanding <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (start) begin
            state       <= LOAD;
            row_cnt     <= '0;
            chunk_cnt   <= '0;
            slice_idx   <= '0;
            err         <= 1'b0;
            outstanding <= 1'b0;
            wait_done   <= 1'b0;
          end
        end

        LOAD: begin
          if (bus.in_valid) begin
            if (row_cnt == ROW_LAST) begin
              row_cnt <= '0;
              state   <= WAIT_MM;
            end else begin
              row_cnt <= row_cnt + RW'(1);
            end
          end
        end

        WAIT_MM: begin
          if (bus.mm_ready) begin
            state       <= STREAM;
            mm_start_q  <= 1'b1;
            outstanding <= 1'b1;
          end
        end

        STREAM: begin
          if (wait_done) begin
            if (bus.mm_done || !outstanding) begin
              wait_done <= 1'b0;
              state     <= WAIT_MM;
            end
          end else begin
            mm_valid_q <= bus.buf_out_valid;
            if (bus.buf_out_valid && chunk_cnt != '1) begin
              chunk_cnt <= chunk_cnt + CW'(1);
            end
            if (bus.buf_slice_done) begin
              chunk_cnt <= '0;
              if (slice_idx == SLICE_LAST) begin
                state <= DRAIN;
              end else begin
                slice_idx <= slice_idx + SIDX_W'(1);
                if (bus.mm_done || !outstanding) begin
                  state <= WAIT_MM;
                end else begin
                  wait_done <= 1'b1;
                end
              end
            end
          end
        end

        DRAIN: begin
          if (bus.mm_done || !outstanding) begin
            state <= DONE;
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase

      // Error sets come after the start-time clear so a fault in that same
      // cycle is not lost.
      if (bus.mm_done && !outstanding) begin
        err <= 1'b1;
      end
      if (bus.buf_slice_done && (state != STREAM || wait_done)) begin
        err <= 1'b1;
      end
      if (state == STREAM && !wait_done && bus.buf_slice_done &&
          chunk_cnt != CHUNK_LAST) begin
        err <= 1'b1;
      end

`ifdef N2R_SLICE_SCHED_WDOG_EN
      if (state inside {WAIT_MM, STREAM, DRAIN}) begin
        if (bus.buf_out_valid || bus.mm_ready || bus.mm_done) begin
          wdog_cnt <= '0;
        end else if (wdog_cnt == WDOG_LAST) begin
          wdog_cnt   <= '0;
          err        <= 1'b1;
          state      <= IDLE;
          wait_done  <= 1'b0;
          mm_valid_q <= 1'b0;
        end else begin
          wdog_cnt <= wdog_cnt + WW'(1);
        end
      end else begin
        wdog_cnt <= '0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_n2r_slice_sched.sv
// tb_n2r_slice_sched
//   Directed bench for n2r_slice_sched with ROW=8, COL=4, BLOCK_SIZE=2,
//   NUM_CORES=2 (two slices of two chunks each) and WDOG_CYCLES=16.
//   Output vector layout: {in_ready, buf_advance, mm_start, mm_valid,
//   slice_idx, busy, done, err}.
module tb_n2r_slice_sched;

  localparam int unsigned ROW  = 8;
  localparam int unsigned COLS = 4;
  localparam int unsigned BS   = 2;
  localparam int unsigned NC   = 2;
  localparam int unsigned WDOG = 16;

`ifdef N2R_SLICE_SCHED_WDOG_EN
  localparam int unsigned BP_CYCLES = 12;
`else
  localparam int unsigned BP_CYCLES = 20;
`endif

  // input vector: {start, in_valid, buf_out_valid, buf_slice_done, mm_ready, mm_done}
  localparam logic [5:0] I_0   = 6'b000000;
  localparam logic [5:0] I_S   = 6'b100000;
  localparam logic [5:0] I_IV  = 6'b010000;
  localparam logic [5:0] I_BOV = 6'b001000;
  localparam logic [5:0] I_BSD = 6'b000100;
  localparam logic [5:0] I_MR  = 6'b000010;
  localparam logic [5:0] I_MD  = 6'b000001;

  typedef struct packed {
    logic [5:0] in;
    logic [7:0] exp;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [0:0] slice_idx;
  logic       busy;
  logic       done;
  logic       err;

  int unsigned n_checks;
  int unsigned n_fail;

  vec_t nom [19];

  n2r_slice_sched_if bus_if ();

  n2r_slice_sched #(
    .ROW         (ROW),
    .COL         (COLS),
    .BLOCK_SIZE  (BS),
    .NUM_CORES   (NC),
    .WDOG_CYCLES (WDOG)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .bus       (bus_if),
    .slice_idx (slice_idx),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] outs();
    return {bus_if.in_ready, bus_if.buf_advance, bus_if.mm_start, bus_if.mm_valid,
            slice_idx, busy, done, err};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic [5:0] v);
    {start, bus_if.in_valid, bus_if.buf_out_valid, bus_if.buf_slice_done,
     bus_if.mm_ready, bus_if.mm_done} = v;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_nominal(input string tag);
    for (int i = 0; i < 19; i++) begin
      step(nom[i].in);
      check($sformatf("%s_v%0d", tag, i), 32'(outs()), 32'(nom[i].exp));
    end
  endtask

  task automatic load_rows();
    for (int i = 0; i < 8; i++) step(I_IV);
  endtask

  initial begin
    int unsigned accepted;
    int unsigned bad;
    logic        iv;

    n_checks = 0;
    n_fail   = 0;

    nom[0]  = '{I_S,                 8'b1100_0100};
    for (int i = 1; i < 8; i++) nom[i] = '{I_IV, 8'b1100_0100};
    nom[8]  = '{I_IV,                8'b0000_0100};
    nom[9]  = '{I_MR,                8'b0110_0100};
    nom[10] = '{I_BOV,               8'b0101_0100};
    nom[11] = '{I_BOV | I_BSD,       8'b0001_1100};
    nom[12] = '{I_MD,                8'b0000_1100};
    nom[13] = '{I_MR,                8'b0110_1100};
    nom[14] = '{I_BOV,               8'b0101_1100};
    nom[15] = '{I_BOV | I_BSD,       8'b0001_1100};
    nom[16] = '{I_0,                 8'b0000_1100};
    nom[17] = '{I_MD,                8'b0000_1110};
    nom[18] = '{I_0,                 8'b0000_1000};

    rst_n = 1'b0;
    {start, bus_if.in_valid, bus_if.buf_out_valid, bus_if.buf_slice_done,
     bus_if.mm_ready, bus_if.mm_done} = I_0;
    @(negedge clk);
    @(negedge clk);
    check("reset_state", 32'(outs()), 32'h0);
    rst_n = 1'b1;
    step(I_0);
    check("idle_after_reset", 32'(outs()), 32'h0);

    // Nominal pass
    run_nominal("nominal");

    // Upstream gaps: in_valid toggles, only 8 rows accepted, in_valid ignored after
    step(I_S);
    accepted = 0;
    bad      = 0;
    for (int i = 0; i < 18; i++) begin
      iv = (i % 2 == 0);
      if (iv && bus_if.in_ready) accepted++;
      step(iv ? I_IV : I_0);
      if (accepted < 8) begin
        if (outs() !== 8'b1100_0100) bad++;
      end else begin
        if (outs() !== 8'b0000_0100) bad++;
      end
    end
    check("gap_rows_accepted", accepted, 8);
    check("gap_state_profile", bad, 0);

    // Slice 0, with slice_done and mm_done in the same cycle
    step(I_MR);
    check("gap_mm_start", 32'(outs()), 32'(8'b0110_0100));
    step(I_BOV);
    step(I_BOV | I_BSD | I_MD);
    check("same_cycle_done", 32'(outs()), 32'(8'b0001_1100));

    // Core backpressure before slice 1
    bad = 0;
    for (int i = 0; i < int'(BP_CYCLES); i++) begin
      step(I_0);
      if (outs() !== 8'b0000_1100) bad++;
    end
    check("bp_frozen", bad, 0);
    step(I_MR);
    check("bp_release", 32'(outs()), 32'(8'b0110_1100));
    step(I_MD);
    check("bp_start_pulse_end", 32'(outs()), 32'(8'b0100_1100));
    step(I_BOV);
    step(I_BOV | I_BSD);
    check("drain_latched", 32'(outs()), 32'(8'b0001_1100));
    step(I_0);
    check("latched_done", 32'(outs()), 32'(8'b0000_1110));
    step(I_0);
    check("idle_after_latched", 32'(outs()), 32'(8'b0000_1000));

    // Protocol fault: slice_done after a single chunk
    step(I_S);
    load_rows();
    step(I_MR);
    step(I_BOV | I_BSD);
    check("fault_err", 32'(outs()), 32'(8'b0001_1101));
    step(I_MD);
    step(I_MR);
    step(I_BOV);
    step(I_BOV | I_BSD);
    step(I_MD);
    check("fault_done", 32'(outs()), 32'(8'b0000_1111));
    step(I_0);
    check("err_sticky_idle", 32'(outs()), 32'(8'b0000_1001));
    step(I_S);
    check("start_clears_err", 32'(outs()), 32'(8'b1100_0100));

    // Reset in the middle of slice 1
    load_rows();
    step(I_MR);
    step(I_BOV);
    step(I_BOV | I_BSD | I_MD);
    step(I_MR);
    step(I_BOV);
    check("pre_reset_stream", 32'(outs()), 32'(8'b0101_1100));
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", 32'(outs()), 32'h0);
    @(negedge clk);
    check("held_reset", 32'(outs()), 32'h0);
    rst_n = 1'b1;
    run_nominal("post_reset");

    // mm_done with no slice outstanding
    step(I_MD);
    check("spurious_mm_done", 32'(outs()), 32'(8'b0000_1001));

    // Drain without mm_done
    step(I_S);
    load_rows();
    step(I_MR);
    step(I_BOV);
    step(I_BOV | I_BSD | I_MD);
    step(I_MR);
    step(I_BOV);
    step(I_BOV | I_BSD);
    check("drain_entry", 32'(outs()), 32'(8'b0001_1100));
`ifdef N2R_SLICE_SCHED_WDOG_EN
    bad = 0;
    for (int i = 0; i < int'(WDOG) - 1; i++) begin
      step(I_0);
      if (outs() !== 8'b0000_1100) bad++;
    end
    check("wdog_hold", bad, 0);
    step(I_0);
    check("wdog_fire", 32'(outs()), 32'(8'b0000_1001));
`else
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      step(I_0);
      if (outs() !== 8'b0000_1100) bad++;
    end
    check("no_wdog_drain", bad, 0);
    step(I_MD);
    check("late_done", 32'(outs()), 32'(8'b0000_1110));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/n2r_slice_sched.md
# n2r_slice_sched

Sequencing controller for the normal-to-ready slice buffer and the multi-MAC matmul cores. Accepts a full matrix row-by-row from upstream, then releases it to the cores one slice (BLOCK_SIZE*NUM_CORES rows) at a time. Each slice is released only after the cores report ready, and the controller freezes the buffer while they are busy. It sits between the row source, the n2r buffer and the core array, and owns all start, stall, done and error signalling for one matrix pass.

## Interface
- ROW, 2754, matrix rows per pass
- COL, 256, matrix columns
- BLOCK_SIZE, 2, systolic block edge
- NUM_CORES, 8, matmul cores fed in parallel
- WDOG_CYCLES, 1024, watchdog limit (used only with macro)
- Derived: SLICE_ROWS=BLOCK_SIZE*NUM_CORES, NUM_SLICES=ceil(ROW/SLICE_ROWS), CHUNKS=COL/BLOCK_SIZE
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin a pass; sampled only in IDLE
- in_valid  in  1  upstream row valid
- in_ready  out  1  controller accepts a row
- buf_advance  out  1  buffer may progress; low freezes buffer state
- buf_out_valid  in  1  buffer presents one chunk this cycle
- buf_slice_done  in  1  buffer emitted last chunk of a slice
- mm_ready  in  1  cores can accept a new slice
- mm_start  out  1  one-cycle pulse, slice begins
- mm_valid  out  1  chunk on buffer output is for cores
- mm_done  in  1  cores finished current slice
- slice_idx  out  clog2(NUM_SLICES)  slice being streamed
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse, pass complete
- err  out  1  sticky protocol error, cleared by accepted start

## Operation
- States: IDLE, LOAD, WAIT_MM, STREAM, DRAIN, DONE.
- IDLE: start=1 -> LOAD. Clear row_cnt, chunk_cnt, slice_idx, err.
- LOAD: in_ready=1, buf_advance=1. Each in_valid&in_ready increments row_cnt. Acceptance at row_cnt==ROW-1 -> WAIT_MM.
- WAIT_MM: buf_advance=0. mm_ready=1 -> STREAM; mm_start=1 in first STREAM cycle.
- STREAM: buf_advance=1, mm_valid=buf_out_valid. chunk_cnt increments on buf_out_valid.
  - On buf_slice_done: chunk_cnt must equal CHUNKS-1, else set err.
  - Then clear chunk_cnt.
  - If slice_idx==NUM_SLICES-1 -> DRAIN.
  - Otherwise slice_idx+1, then wait for mm_done. If mm_done is seen in the same or a later cycle -> WAIT_MM.
  - mm_done seen during STREAM is latched.
- DRAIN: buf_advance=0, wait mm_done (or latched) -> DONE.
- DONE: done=1 for one cycle -> IDLE.
- err set also by buf_slice_done outside STREAM, and by mm_done with no slice outstanding. err is sticky; the FSM continues.
- start while busy is ignored. in_valid outside LOAD is ignored (in_ready=0).
- slice_idx never wraps within a pass. The last slice may be partial (ROW not a multiple of SLICE_ROWS); the buffer zero-pads it.

## Timing
- All outputs registered or decoded from the state register; no combinational input-to-output path.
- Reset values: in_ready=0, buf_advance=0, mm_start=0, mm_valid=0, slice_idx=0, busy=0, done=0, err=0, state=IDLE.
- start at edge t -> LOAD, busy=1, in_ready=1 from t+1.
- LOAD lasts ≥ROW cycles. Exit the cycle after the last accepted row.
- mm_ready seen at edge t in WAIT_MM -> mm_start and buf_advance high at t+1.
- buf_slice_done and mm_done in the same cycle: both honoured (mm_done is for the prior slice).
- rst_n low mid-pass: immediate return to reset values. No partial done; the pass is lost.

## Configuration
- N2R_SLICE_SCHED_WDOG_EN defined: a cycle counter runs in WAIT_MM, STREAM and DRAIN.
  - It resets on any buf_out_valid, mm_ready or mm_done.
  - At WDOG_CYCLES it sets err and forces IDLE (busy=0, no done pulse).
- Undefined: no counter, no forced exit; the FSM may wait indefinitely.

## Test plan
(ROW=8, COL=4, BLOCK_SIZE=2, NUM_CORES=2 -> SLICE_ROWS=4, NUM_SLICES=2, CHUNKS=2)
- Nominal pass: start, 8 rows back-to-back, mm_ready=1, slice_done after 2 chunks, mm_done after each slice -> two mm_start pulses with slice_idx 0 then 1, done one cycle, err=0.
- Upstream gaps: in_valid toggling 1,0 -> exactly 8 rows accepted, WAIT_MM entered only after 8th.
- Core backpressure: mm_ready=0 for 20 cycles before slice 1 -> buf_advance=0 for those cycles, mm_start one cycle after mm_ready rises.
- Protocol fault: buf_slice_done after 1 chunk -> err=1 and stays 1 until next start.
- Reset mid-STREAM: rst_n low at slice 1 -> all outputs at reset values asynchronously; new start runs a clean pass.
- Watchdog (macro on, WDOG_CYCLES=16): mm_done never arrives -> err=1 and IDLE 16 cycles after last activity; macro off -> still in DRAIN after 100 cycles.
